spi_reg_slave: RTL

//  SPI mode-0 slave (responder) at the host-facing edge of the FourierTransform top.

---
 rtl/spi_reg_slave_if.sv | 26 ++
 rtl/spi_reg_slave.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave_if.sv
// Register-bus bundle between the SPI front end and the register file.
//   reg_addr/reg_wdata/reg_we/reg_re : driven by the SPI slave (master modport)
//   reg_rdata/reg_rvalid/reg_err     : driven by the register file (slave modport)
`timescale 1ns/1ps
interface spi_reg_slave_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32
);
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic          reg_we;
    logic          reg_re;
    logic [DW-1:0] reg_rdata;
    logic          reg_rvalid;
    logic          reg_err;

    modport master (
        output reg_addr, reg_wdata, reg_we, reg_re,
        input  reg_rdata, reg_rvalid, reg_err
    );

    modport slave (
        input  reg_addr, reg_wdata, reg_we, reg_re,
        output reg_rdata, reg_rvalid, reg_err
    );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave that turns host frames into single-cycle register-bus strobes.
// Frame: 32b header {wr, ignored, addr}, 32b data, [8b CRC], 8b status {4'hA, misalign,
// crc_err, rd_timeout, reg_err}. MOSI sampled on sck rise, MISO updated on sck fall.
// Ports:
//   clk, rstn                 system clock, async active-low reset
//   spi_sck/spi_ss_n/spi_mosi SPI inputs, asynchronous to clk
//   spi_miso                  SPI output, 0 while deselected
//   busy                      high from ss_n fall to end of frame
//   bus (master modport)      register address/data/strobes and read response
// Optional feature: define SPI_CRC8_EN to add the CRC-8 (poly 0x07) field.
`timescale 1ns/1ps
module spi_reg_slave #(
    parameter int unsigned AW          = 16,
    parameter int unsigned DW          = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RD_TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            spi_sck,
    input  logic            spi_ss_n,
    input  logic            spi_mosi,
    output logic            spi_miso,
    output logic            busy,
    spi_reg_slave_if.master bus
);

`ifdef SPI_CRC8_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    localparam int unsigned CW = $clog2(DW);
    localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_WR_DATA, S_RD_REQ, S_RD_DATA, S_CRC, S_STAT
    } state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sck_prev_q, ss_prev_q;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] sh_q, sh_d;
    logic [7:0]    crc_q, crc_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          is_wr_q, is_wr_d;
    logic          misal_q, misal_d;
    logic          crc_err_q, crc_err_d;
    logic          tmo_err_q, tmo_err_d;
    logic          reg_err_q, reg_err_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          re_q, re_d;
    logic          miso_q, miso_d;
    logic          busy_q, busy_d;

    logic          sck_s, ss_s, mosi_s;
    logic          sck_rise, sck_fall, ss_fall;
    logic [DW-1:0] shifted;
    logic [7:0]    crc_next;
    logic [7:0]    stat_byte;
    logic          last32, last8;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign ss_fall  = ss_prev_q & ~ss_s;

    assign shifted   = {sh_q[DW-2:0], mosi_s};
    // Serial CRC-8, poly x^8+x^2+x+1, MSB first.
    assign crc_next  = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ mosi_s) ? 8'h07 : 8'h00);
    assign stat_byte = {4'hA, misal_q, crc_err_q, tmo_err_q, reg_err_q};
    assign last32    = (cnt_q == CW'(DW - 1));
    assign last8     = (cnt_q == CW'(7));

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        crc_d     = crc_q;
        tmo_d     = tmo_q;
        is_wr_d   = is_wr_q;
        misal_d   = misal_q;
        crc_err_d = crc_err_q;
        tmo_err_d = tmo_err_q;
        reg_err_d = reg_err_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        miso_d    = miso_q;
        busy_d    = busy_q;

        // Write error response arrives in the same cycle as the strobe.
        if (we_q && bus.reg_err) begin
            reg_err_d = 1'b1;
        end

        if (state_q == S_IDLE) begin
            miso_d = 1'b0;
            busy_d = 1'b0;
            if (ss_fall) begin
                state_d   = S_HDR;
                busy_d    = 1'b1;
                cnt_d     = '0;
                sh_d      = '0;
                crc_d     = '0;
                tmo_d     = '0;
                is_wr_d   = 1'b0;
                misal_d   = 1'b0;
                crc_err_d = 1'b0;
                tmo_err_d = 1'b0;
                reg_err_d = 1'b0;
            end
        end else if (ss_s) begin
            // Deselect mid-frame: drop everything; a pending read is simply forgotten.
            state_d = S_IDLE;
            busy_d  = 1'b0;
            miso_d  = 1'b0;
        end else begin
            if (sck_fall) begin
                case (state_q)
                    S_RD_DATA: miso_d = rdata_q[CW'(DW - 1) - cnt_q];
                    S_STAT:    miso_d = stat_byte[3'd7 - cnt_q[2:0]];
                    default:   miso_d = 1'b0;
                endcase
            end

            case (state_q)
                S_HDR: begin
                    if (sck_rise) begin
                        sh_d  = shifted;
                        crc_d = crc_next;
                        cnt_d = cnt_q + CW'(1);
                        if (last32) begin
                            cnt_d   = '0;
                            sh_d    = '0;
                            addr_d  = shifted[AW-1:0];
                            is_wr_d = shifted[DW-1];
                            misal_d = |shifted[1:0];
                            if (shifted[DW-1]) begin
                                state_d = S_WR_DATA;
                            end else if (|shifted[1:0]) begin
                                state_d = S_RD_DATA;
                                rdata_d = '0;
                            end else begin
                                state_d = S_RD_REQ;
                                re_d    = 1'b1;
                                tmo_d   = '0;
                            end
                        end
                    end
                end
                S_WR_DATA, S_RD_DATA: begin
                    if (sck_rise) begin
                        sh_d  = shifted;
                        crc_d = crc_next;
                        cnt_d = cnt_q + CW'(1);
                        if (last32) begin
                            cnt_d = '0;
                            sh_d  = '0;
                            if (state_q == S_WR_DATA && !misal_q) begin
                                wdata_d = shifted;
                            end
                            if (CRC_EN) begin
                                state_d = S_CRC;
                            end else begin
                                state_d = S_STAT;
                                we_d    = (state_q == S_WR_DATA) && !misal_q;
                            end
                        end
                    end
                end
                S_RD_REQ: begin
                    if (bus.reg_rvalid) begin
                        rdata_d = bus.reg_rdata;
                        if (bus.reg_err) begin
                            reg_err_d = 1'b1;
                        end
                        state_d = S_RD_DATA;
                    end else if (tmo_q == TW'(RD_TIMEOUT - 1)) begin
                        rdata_d   = '0;
                        tmo_err_d = 1'b1;
                        state_d   = S_RD_DATA;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                S_CRC: begin
                    if (sck_rise) begin
                        sh_d  = shifted;
                        cnt_d = cnt_q + CW'(1);
                        if (last8) begin
                            cnt_d   = '0;
                            sh_d    = '0;
                            state_d = S_STAT;
                            if (shifted[7:0] != crc_q) begin
                                crc_err_d = 1'b1;
                            end else begin
                                we_d = is_wr_q && !misal_q;
                            end
                        end
                    end
                end
                S_STAT: begin
                    if (sck_rise) begin
                        cnt_d = cnt_q + CW'(1);
                        if (last8) begin
                            cnt_d   = '0;
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Synchronisers, edge history and all state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            crc_q       <= '0;
            tmo_q       <= '0;
            is_wr_q     <= 1'b0;
            misal_q     <= 1'b0;
            crc_err_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
            reg_err_q   <= 1'b0;
            rdata_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_prev_q  <= sck_s;
            ss_prev_q   <= ss_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            crc_q       <= crc_d;
            tmo_q       <= tmo_d;
            is_wr_q     <= is_wr_d;
            misal_q     <= misal_d;
            crc_err_q   <= crc_err_d;
            tmo_err_q   <= tmo_err_d;
            reg_err_q   <= reg_err_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
        end
    end

    assign spi_miso      = miso_q;
    assign busy          = busy_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_we    = we_q;
    assign bus.reg_re    = re_q;

endmodule
